// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared FSM encodings and source ids for the round-robin mux arbiter.
`default_nettype none

package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mux2_w.sv
// mux2_w: parameterised WIDTH-bit 2:1 mux, sel = 0 picks in0.
`default_nettype none

module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter owning the select of a shared 2:1 mux.
// Optional per-source transfer counters are enabled with MUX_ARB_STATS_EN.
`default_nettype none

module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel,
  output logic             busy
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
`endif
);

  localparam int            CW        = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_t        state, state_d;
  logic          sel_d;
  logic          last, last_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          a_xfer, b_xfer;

  assign a_xfer = (state == GNT_A) && a_valid && y_ready;
  assign b_xfer = (state == GNT_B) && b_valid && y_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= SRC_A;
      last  <= SRC_B;
      cnt   <= '0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      last  <= last_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    sel_d   = sel;
    last_d  = last;
    cnt_d   = cnt;
    y_valid = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the source that was not served last wins.
        if (a_valid && (!b_valid || last == SRC_B)) begin
          state_d = GNT_A;
          sel_d   = SRC_A;
          last_d  = SRC_A;
          cnt_d   = '0;
        end else if (b_valid) begin
          state_d = GNT_B;
          sel_d   = SRC_B;
          last_d  = SRC_B;
          cnt_d   = '0;
        end
      end
      GNT_A: begin
        y_valid = a_valid;
        a_ready = y_ready;
        if (!a_valid || (a_xfer && cnt == LAST_BEAT)) begin
          cnt_d = '0;
          if (b_valid) begin
            state_d = GNT_B;
            sel_d   = SRC_B;
            last_d  = SRC_B;
          end else if (a_valid) begin
            last_d  = SRC_A;
          end else begin
            state_d = IDLE;
          end
        end else if (a_xfer) begin
          cnt_d = cnt + 1'b1;
        end
      end
      GNT_B: begin
        y_valid = b_valid;
        b_ready = y_ready;
        if (!b_valid || (b_xfer && cnt == LAST_BEAT)) begin
          cnt_d = '0;
          if (a_valid) begin
            state_d = GNT_A;
            sel_d   = SRC_A;
            last_d  = SRC_A;
          end else if (b_valid) begin
            last_d  = SRC_B;
          end else begin
            state_d = IDLE;
          end
        end else if (b_xfer) begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  mux2_w #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(sel),
    .in0(a_data),
    .in1(b_data),
    .out(y_data)
  );

`ifdef MUX_ARB_STATS_EN
  logic [15:0] cnt_a_q;
  logic [15:0] cnt_b_q;

  // Saturating counters: they hold at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (a_xfer && cnt_a_q != 16'hFFFF) cnt_a_q <= cnt_a_q + 16'd1;
      if (b_xfer && cnt_b_q != 16'hFFFF) cnt_b_q <= cnt_b_q + 16'd1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench for mux_rr_arbiter (stats checks under MUX_ARB_STATS_EN).
`default_nettype none

module tb_mux_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int MB    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic             y_valid, y_ready, sel, busy;
  logic [WIDTH-1:0] a_data, b_data, y_data;
`ifdef MUX_ARB_STATS_EN
  logic [15:0]      cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .WIDTH(WIDTH),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_valid(a_valid),
    .a_data(a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data(b_data),
    .b_ready(b_ready),
    .y_valid(y_valid),
    .y_data(y_data),
    .y_ready(y_ready),
    .sel(sel),
    .busy(busy)
`ifdef MUX_ARB_STATS_EN
    ,
    .cnt_a(cnt_a),
    .cnt_b(cnt_b)
`endif
  );

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] aq[$];
  logic [WIDTH-1:0] bq[$];
  logic             a_en, b_en;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               steps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void drive();
    a_valid = a_en && (aq.size() > 0);
    a_data  = a_valid ? aq[0] : '0;
    b_valid = b_en && (bq.size() > 0);
    b_data  = b_valid ? bq[0] : '0;
  endfunction

  // Sample before the edge, then retire producer beats and re-drive after it.
  task automatic step();
    exp_t e;
    logic fa, fb;
    #4;
    fa = a_valid && a_ready;
    fb = b_valid && b_ready;
    check("hs_match", {31'd0, y_valid && y_ready}, {31'd0, fa || fb});
    if (y_valid && y_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra", y_data, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("y_data", y_data, e.data);
        check("y_sel", sel, e.sel);
      end
    end
    @(posedge clk);
    #1;
    if (fa) void'(aq.pop_front());
    if (fb) void'(bq.pop_front());
    drive();
  endtask

  // Expected order with both sources streaming: bursts of up to MB, alternating, A first.
  task automatic load(input int na, input int nb, input logic [7:0] abase, input logic [7:0] bbase);
    exp_t e;
    int   ia = 0;
    int   ib = 0;
    int   k;
    logic cur = 1'b0;
    for (int i = 0; i < na; i++) aq.push_back(8'(abase + i));
    for (int i = 0; i < nb; i++) bq.push_back(8'(bbase + i));
    while (ia < na || ib < nb) begin
      if (!cur && ia >= na) cur = 1'b1;
      else if (cur && ib >= nb) cur = 1'b0;
      k = 0;
      while (k < MB && (cur ? (ib < nb) : (ia < na))) begin
        e.sel  = cur;
        e.data = cur ? 8'(bbase + ib) : 8'(abase + ia);
        sb.push_back(e);
        if (cur) ib++; else ia++;
        k++;
      end
      cur = ~cur;
    end
  endtask

  task automatic run(input int max_steps, input int stall_lo, input int stall_hi, output int n);
    n = 0;
    while ((sb.size() > 0 || aq.size() > 0 || bq.size() > 0) && n < max_steps) begin
      y_ready = !(n >= stall_lo && n <= stall_hi);
      #1;
      if (!y_ready && sb.size() > 0) begin
        check("bp_a_ready", a_ready, 0);
        check("bp_y_valid", y_valid, 1);
        check("bp_y_data", y_data, sb[0].data);
      end
      step();
      n++;
    end
    check("run_done", sb.size(), 0);
    y_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_en  = 1'b0;
    b_en  = 1'b0;
    aq.delete();
    bq.delete();
    sb.delete();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset held with both sources requesting.
    rst_n   = 1'b0;
    y_ready = 1'b1;
    a_en    = 1'b1;
    b_en    = 1'b1;
    aq.push_back(8'hEE);
    bq.push_back(8'hDD);
    drive();
    @(posedge clk);
    #1;
    repeat (3) begin
      #4;
      check("rst_y_valid", y_valid, 0);
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      check("rst_sel", sel, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;
    end

    // Single source A.
    do_reset();
    a_en = 1'b1;
    aq.push_back(8'h11);
    aq.push_back(8'h22);
    aq.push_back(8'h33);
    e.sel = 1'b0;
    e.data = 8'h11; sb.push_back(e);
    e.data = 8'h22; sb.push_back(e);
    e.data = 8'h33; sb.push_back(e);
    drive();
    run(20, -1, -1, steps);
    check("single_cycles", steps, 4);
    step();
    check("single_idle_busy", busy, 0);
    check("single_idle_y_valid", y_valid, 0);

    // Continuous contention: 4 A, 4 B, 4 A, 4 B with no idle cycles.
    do_reset();
    a_en = 1'b1;
    b_en = 1'b1;
    load(8, 8, 8'hA0, 8'hB0);
    drive();
    run(60, -1, -1, steps);
    check("contend_cycles", steps, 17);

    // Backpressure for 5 cycles after two A beats; A burst still totals 4.
    do_reset();
    a_en = 1'b1;
    b_en = 1'b1;
    load(6, 2, 8'h40, 8'h50);
    drive();
    run(60, 3, 7, steps);

    // Reset asserted mid-burst from B.
    do_reset();
    b_en = 1'b1;
    for (int i = 0; i < 4; i++) bq.push_back(8'(8'h60 + i));
    e.sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.data = 8'(8'h60 + i);
      sb.push_back(e);
    end
    drive();
    step();
    step();
    step();
    rst_n = 1'b0;
    a_en  = 1'b1;
    aq.push_back(8'h70);
    aq.push_back(8'h71);
    drive();
    step();
    rst_n = 1'b1;
    #1;
    check("mrst_sel", sel, 0);
    check("mrst_busy", busy, 0);
    check("mrst_y_valid", y_valid, 0);
    check("mrst_a_ready", a_ready, 0);
    e.sel = 1'b0;
    e.data = 8'h70; sb.push_back(e);
    e.data = 8'h71; sb.push_back(e);
    e.sel = 1'b1;
    e.data = 8'h63; sb.push_back(e);
    run(40, -1, -1, steps);

`ifdef MUX_ARB_STATS_EN
    do_reset();
    check("stats_rst_a", cnt_a, 0);
    check("stats_rst_b", cnt_b, 0);
    a_en = 1'b1;
    b_en = 1'b1;
    load(10, 6, 8'h00, 8'h80);
    drive();
    run(80, -1, -1, steps);
    check("stats_cnt_a", cnt_a, 10);
    check("stats_cnt_b", cnt_b, 6);
    force dut.cnt_a_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.cnt_a_q;
    b_en = 1'b0;
    load(3, 0, 8'hC0, 8'h00);
    drive();
    run(40, -1, -1, steps);
    check("stats_sat_a", cnt_a, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
